mod100_up_counter_display: RTL and testbench

Two-digit BCD up counter, 00 to 99, that advances once per prescaled tick and drives a two-digit multiplexed seven-segment display on the Nexys 4 DDR board. It complements the board-level mod-100 down counter: same display interface and encoding, opposite count direction, plus a count enable and a wrap strobe. It is a top-level board block on the single 100 MHz system clock, with prescalers and the display scanner built in.

---
 rtl/mod100_disp_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/mod100_up_counter_display.sv | 128 ++++++++++++
 tb/tb_mod100_up_counter_display.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mod100_disp_pkg.sv
// Shared constants for the two-digit seven-segment display: active-low segment
// patterns {DP,g,f,e,d,c,b,a} and anode selects for the ones/tens digits.
package mod100_disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] AN_ONES   = 8'b1111_1110;
    localparam logic [7:0] AN_TENS   = 8'b1111_1101;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern; DP is always off
// and any non-decimal code blanks the digit.
module bcd_to_seg7
    import mod100_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Digit lookup.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mod100_up_counter_display.sv
// Two-digit BCD up counter 00..99 with count enable and wrap strobe, driving a
// two-digit multiplexed seven-segment display from built-in prescalers.
module mod100_up_counter_display
    import mod100_disp_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned SCAN_DIV = 100_000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    output logic [7:0] AN,
    output logic [7:0] CA,
    output logic       WRAP
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]        ones_q, ones_d;
    logic [3:0]        tens_q, tens_d;
    slot_e             slot_q, slot_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        ca_q, ca_d;
    logic              wrap_q, wrap_d;
    logic              tick_s, scan_s;
    logic [7:0]        seg_ones_s, seg_tens_s;

    bcd_to_seg7 u_seg_ones (.bcd(ones_q), .seg(seg_ones_s));
    bcd_to_seg7 u_seg_tens (.bcd(tens_q), .seg(seg_tens_s));

    // Free-running tick and scan prescalers.
    always_comb begin
        tick_s = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        scan_s = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (scan_s) begin
            scan_cnt_d = '0;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    // BCD count; the >= compares keep the digits inside 0..9 even from a bad state.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (tick_s && EN) begin
            if (ones_q >= 4'd9) begin
                ones_d = 4'd0;
                if (tens_q >= 4'd9) begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else begin
            ones_d = ones_q;
            tens_d = tens_q;
        end
    end

    // Scanner: display registers load from the post-toggle slot using the
    // digits as they were before any coincident count update.
    always_comb begin
        slot_d = slot_q;
        an_d   = an_q;
        ca_d   = ca_q;
        if (scan_s) begin
            slot_d = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
            case (slot_d)
                SLOT_ONES: begin
                    an_d = AN_ONES;
                    ca_d = seg_ones_s;
                end
                SLOT_TENS: begin
                    an_d = AN_TENS;
                    ca_d = (BLANK_LZ && (tens_q == 4'd0)) ? SEG_BLANK : seg_tens_s;
                end
                default: begin
                    an_d = AN_OFF;
                    ca_d = SEG_BLANK;
                end
            endcase
        end else begin
            slot_d = slot_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            slot_q     <= SLOT_TENS;
            an_q       <= AN_OFF;
            ca_q       <= SEG_BLANK;
            wrap_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            slot_q     <= slot_d;
            an_q       <= an_d;
            ca_q       <= ca_d;
            wrap_q     <= wrap_d;
        end
    end

    assign AN   = an_q;
    assign CA   = ca_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_mod100_up_counter_display.sv
// Scoreboard bench: dut_a (TICK_DIV=4, SCAN_DIV=2, blanking on) and dut_b
// (TICK_DIV=4, SCAN_DIV=4, blanking off) run side by side from one stimulus.
module tb_mod100_up_counter_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] an_a, ca_a, an_b, ca_b;
    logic       wrap_a, wrap_b;

    always #5 clk = ~clk;

    mod100_up_counter_display #(.TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1'b1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .EN(en), .AN(an_a), .CA(ca_a), .WRAP(wrap_a)
    );

    mod100_up_counter_display #(.TICK_DIV(4), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .CLK(clk), .RST_N(rst_n), .EN(en), .AN(an_b), .CA(ca_b), .WRAP(wrap_b)
    );

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          wexp_a[$];
    int          wexp_b[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          edge_no = 0;
    logic        in_rst = 1'b0;
    logic        finish_req = 1'b0;
    logic [7:0]  prev_an_a = 'x;
    logic [7:0]  prev_an_b = 'x;
    int          c = 0;
    int          p_local = 0;

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Non-reset edge counter and a record of whether the last edge was a reset edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            edge_no <= 0;
            in_rst  <= 1'b1;
        end else begin
            edge_no <= edge_no + 1;
            in_rst  <= 1'b0;
        end
    end

    // Monitor: pops on every AN change and every WRAP cycle; also owns the summary.
    always @(negedge clk) begin
        logic [15:0] e;
        int w;
        if (finish_req) begin
            n_vec++;
            if (exp_a.size() != 0 || exp_b.size() != 0 || wexp_a.size() != 0 || wexp_b.size() != 0) begin
                n_err++;
                $display("FAIL leftover: disp_a=%0d disp_b=%0d wrap_a=%0d wrap_b=%0d pending, required 0",
                         exp_a.size(), exp_b.size(), wexp_a.size(), wexp_b.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else begin
            if (in_rst) begin
                n_vec++;
                if ({an_a, ca_a, wrap_a} !== {8'hFF, 8'hFF, 1'b0} || {an_b, ca_b, wrap_b} !== {8'hFF, 8'hFF, 1'b0}) begin
                    n_err++;
                    $display("FAIL reset_outputs: a AN=%h CA=%h WRAP=%b b AN=%h CA=%h WRAP=%b, required FF FF 0",
                             an_a, ca_a, wrap_a, an_b, ca_b, wrap_b);
                end
            end
            if (an_a !== prev_an_a) begin
                n_vec++;
                if (exp_a.size() == 0) begin
                    n_err++;
                    $display("FAIL disp_a: AN=%h CA=%h at edge %0d, required no update", an_a, ca_a, edge_no);
                end else begin
                    e = exp_a.pop_front();
                    if ({an_a, ca_a} !== e) begin
                        n_err++;
                        $display("FAIL disp_a: AN=%h CA=%h at edge %0d, required AN=%h CA=%h",
                                 an_a, ca_a, edge_no, e[15:8], e[7:0]);
                    end
                end
            end
            if (an_b !== prev_an_b) begin
                n_vec++;
                if (exp_b.size() == 0) begin
                    n_err++;
                    $display("FAIL disp_b: AN=%h CA=%h at edge %0d, required no update", an_b, ca_b, edge_no);
                end else begin
                    e = exp_b.pop_front();
                    if ({an_b, ca_b} !== e) begin
                        n_err++;
                        $display("FAIL disp_b: AN=%h CA=%h at edge %0d, required AN=%h CA=%h",
                                 an_b, ca_b, edge_no, e[15:8], e[7:0]);
                    end
                end
            end
            if (wrap_a !== 1'b0) begin
                n_vec++;
                w = (wexp_a.size() == 0) ? -1 : wexp_a.pop_front();
                if (w != edge_no) begin
                    n_err++;
                    $display("FAIL wrap_a: WRAP=%b after edge %0d, required pulse after edge %0d", wrap_a, edge_no, w);
                end
            end
            if (wrap_b !== 1'b0) begin
                n_vec++;
                w = (wexp_b.size() == 0) ? -1 : wexp_b.pop_front();
                if (w != edge_no) begin
                    n_err++;
                    $display("FAIL wrap_b: WRAP=%b after edge %0d, required pulse after edge %0d", wrap_b, edge_no, w);
                end
            end
        end
        prev_an_a <= an_a;
        prev_an_b <= an_b;
    end

    // One tick period (4 clocks) per iteration; expected scans are pushed up front.
    task automatic run_periods(input int n, input logic en_val);
        for (int i = 0; i < n; i++) begin
            en = en_val;
            exp_a.push_back({8'hFE, seg(c % 10)});
            exp_a.push_back({8'hFD, (c / 10 == 0) ? 8'hFF : seg(c / 10)});
            if (p_local % 2 == 0) begin
                exp_b.push_back({8'hFE, seg(c % 10)});
            end else begin
                exp_b.push_back({8'hFD, seg(c / 10)});
            end
            if (en_val && c == 99) begin
                wexp_a.push_back(4 * p_local + 4);
                wexp_b.push_back(4 * p_local + 4);
            end
            repeat (4) @(posedge clk);
            #2;
            if (en_val) begin
                c = (c + 1) % 100;
            end
            p_local++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        exp_a.push_back({8'hFF, 8'hFF});
        exp_b.push_back({8'hFF, 8'hFF});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_periods(100, 1'b1);
        run_periods(37, 1'b1);
        run_periods(10, 1'b0);
        run_periods(62, 1'b1);

        // Count is 99: reset lands on the tick edge, so no wrap may follow.
        en = 1'b1;
        exp_a.push_back({8'hFE, seg(9)});
        exp_a.push_back({8'hFF, 8'hFF});
        exp_b.push_back({8'hFF, 8'hFF});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        c       = 0;
        p_local = 0;

        run_periods(12, 1'b1);
        @(posedge clk);
        #2;
        finish_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

endmodule
